// File: rtl/mips_bus_cpu_if.sv
// Avalon-MM master/slave signal bundle shared by instruction fetch and data access.
// Word-wide transfers only; waitrequest stalls the master with its strobes held.
interface mips_bus_cpu_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_cpu.sv
// Multicycle MIPS-I subset CPU on one Avalon-MM port; fetch = 2 cycles + stalls, EXEC 1, LW/SW +1 + stalls.
// Registered strobes are held unchanged while waitrequest is high; halts when fetching address 0.
module mips_bus_cpu #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0004
) (
    input  logic           clk,
    input  logic           reset,
    output logic           active,
    output logic [31:0]    register_v0,
    mips_bus_cpu_if.master bus
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] tgt_q, tgt_d;
    logic        dly_q, dly_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] gpr_q [32];

    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_val;
    logic        take;
    logic [31:0] nxt_tgt;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_v, rt_v, imm_s, imm_z, pc4, pc8, br_tgt, j_tgt, ea;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign rs_v   = gpr_q[rs];
    assign rt_v   = gpr_q[rt];
    assign imm_s  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_z  = {16'h0000, ir_q[15:0]};
    assign pc4    = pc_q + 32'd4;
    assign pc8    = pc_q + 32'd8;
    assign br_tgt = pc4 + (imm_s << 2);
    assign j_tgt  = {pc4[31:28], ir_q[25:0], 2'b00};
    assign ea     = rs_v + imm_s;

    assign active          = (state_q != S_HALT);
    assign register_v0     = gpr_q[2];
    assign bus.read        = rd_q;
    assign bus.write       = wr_q;
    assign bus.address     = addr_q;
    assign bus.writedata   = wdata_q;
    assign bus.byteenable  = 4'b1111;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        tgt_d   = tgt_q;
        dly_d   = dly_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wb_en   = 1'b0;
        wb_idx  = rt;
        wb_val  = '0;
        take    = 1'b0;
        nxt_tgt = br_tgt;
        unique case (state_q)
            S_FETCH: begin
                if (!rd_q) begin
                    if (pc_q == 32'd0) begin
                        state_d = S_HALT;
                    end else begin
                        rd_d   = 1'b1;
                        addr_d = pc_q & ~32'h3;
                    end
                end else if (!bus.waitrequest) begin
                    rd_d    = 1'b0;
                    ir_d    = bus.readdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // A pending redirect from the previous branch wins over sequential flow.
                state_d = S_FETCH;
                pc_d    = dly_q ? tgt_q : pc4;
                dly_d   = 1'b0;
                case (opcode)
                    6'h00: begin
                        wb_en  = 1'b1;
                        wb_idx = rd;
                        case (funct)
                            6'h21: wb_val = rs_v + rt_v;
                            6'h23: wb_val = rs_v - rt_v;
                            6'h24: wb_val = rs_v & rt_v;
                            6'h25: wb_val = rs_v | rt_v;
                            6'h26: wb_val = rs_v ^ rt_v;
                            6'h2A: wb_val = {31'b0, $signed(rs_v) < $signed(rt_v)};
                            6'h2B: wb_val = {31'b0, rs_v < rt_v};
                            6'h00: wb_val = rt_v << shamt;
                            6'h02: wb_val = rt_v >> shamt;
                            6'h03: wb_val = $signed(rt_v) >>> shamt;
                            6'h08: begin wb_en = 1'b0; take = 1'b1; nxt_tgt = rs_v; end
                            6'h09: begin take = 1'b1; nxt_tgt = rs_v; wb_val = pc8; end
                            default: wb_en = 1'b0;
                        endcase
                    end
                    6'h01: take = ((rt == 5'd0) && rs_v[31]) || ((rt == 5'd1) && !rs_v[31]);
                    6'h02: begin take = 1'b1; nxt_tgt = j_tgt; end
                    6'h03: begin
                        take    = 1'b1;
                        nxt_tgt = j_tgt;
                        wb_en   = 1'b1;
                        wb_idx  = 5'd31;
                        wb_val  = pc8;
                    end
                    6'h04: take = (rs_v == rt_v);
                    6'h05: take = (rs_v != rt_v);
                    6'h06: take = rs_v[31] || (rs_v == 32'd0);
                    6'h07: take = !rs_v[31] && (rs_v != 32'd0);
                    6'h09: begin wb_en = 1'b1; wb_val = rs_v + imm_s; end
                    6'h0A: begin wb_en = 1'b1; wb_val = {31'b0, $signed(rs_v) < $signed(imm_s)}; end
                    6'h0B: begin wb_en = 1'b1; wb_val = {31'b0, rs_v < imm_s}; end
                    6'h0C: begin wb_en = 1'b1; wb_val = rs_v & imm_z; end
                    6'h0D: begin wb_en = 1'b1; wb_val = rs_v | imm_z; end
                    6'h0E: begin wb_en = 1'b1; wb_val = rs_v ^ imm_z; end
                    6'h0F: begin wb_en = 1'b1; wb_val = {ir_q[15:0], 16'h0000}; end
                    6'h23: begin rd_d = 1'b1; addr_d = ea & ~32'h3; state_d = S_MEM; end
                    6'h2B: begin
                        wr_d    = 1'b1;
                        addr_d  = ea & ~32'h3;
                        wdata_d = rt_v;
                        state_d = S_MEM;
                    end
                    default: ;
                endcase
                if (take) begin
                    dly_d = 1'b1;
                    tgt_d = nxt_tgt;
                end
            end
            S_MEM: begin
                if (!bus.waitrequest) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_FETCH;
                    if (rd_q) begin
                        wb_en  = 1'b1;
                        wb_val = bus.readdata;
                    end
                end
            end
            S_HALT: ;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            tgt_q   <= '0;
            dly_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            tgt_q   <= tgt_d;
            dly_q   <= dly_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // $0 is never written, so it reads back as zero without a special case.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else if (wb_en && (wb_idx != 5'd0)) begin
            gpr_q[wb_idx] <= wb_val;
        end
    end

endmodule

// File: tb/tb_mips_bus_cpu.sv
// Bench for mips_bus_cpu: RAM slave with configurable stalls, directed programs and
// random programs checked against an instruction-level reference model.
module tb_mips_bus_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;

    mips_bus_cpu_if bus ();

    mips_bus_cpu #(.RESET_VECTOR(32'h0000_0004)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem      [512];
    logic [31:0] load_buf [512];
    logic [31:0] rmem     [512];
    bit          load_req = 1'b0;
    int          stall_mode = 0;
    int          stall_n = 0;
    int          mon_viol = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        if (load_req) mem = load_buf;
        else if (reset && bus.write && !bus.waitrequest) mem[bus.address[10:2]] = bus.writedata;
    end
    assign bus.readdata = mem[bus.address[10:2]];

    // Slave stall generator plus bus protocol monitor.
    int          wcnt = 0;
    bit          held = 1'b0;
    logic [65:0] prev_bus;
    always @(negedge clk) begin
        if (reset) begin
            if (held && ({bus.read, bus.write, bus.address, bus.writedata} !== prev_bus)) begin
                mon_viol++;
                $display("FAIL stall_hold: got %h required %h", {bus.read, bus.write, bus.address, bus.writedata}, prev_bus);
            end
            if (bus.read && bus.write) begin
                mon_viol++;
                $display("FAIL rd_wr_same_cycle: got read=1 write=1 required not both");
            end
            if (bus.address[1:0] != 2'b00) begin
                mon_viol++;
                $display("FAIL addr_align: got %h required low bits 00", bus.address);
            end
            if (!active && (bus.read || bus.write)) begin
                mon_viol++;
                $display("FAIL halted_strobe: got read=%b write=%b required 0", bus.read, bus.write);
            end
        end
        if (bus.read || bus.write) begin
            if (stall_mode == 1) begin
                bus.waitrequest = (wcnt < stall_n);
                wcnt++;
            end else if (stall_mode == 2) begin
                bus.waitrequest = ($urandom_range(0, 2) == 0);
            end else begin
                bus.waitrequest = 1'b0;
            end
        end else begin
            wcnt = 0;
            bus.waitrequest = 1'b0;
        end
        held     = reset && (bus.read || bus.write) && bus.waitrequest;
        prev_bus = {bus.read, bus.write, bus.address, bus.writedata};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic commit_load();
        reset = 1'b0;
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int budget, output int cyc, output bit ok);
        cyc = 0;
        while (active && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        ok = !active;
    endtask

    task automatic finish_run(input string nm, input logic [31:0] exp_v0, input int viol0);
        int  cyc;
        bit  ok;
        wait_halt(4000, cyc, ok);
        check({nm, "_halted"}, 32'(ok), 32'd1);
        check({nm, "_v0"}, register_v0, exp_v0);
        repeat (6) @(negedge clk);
        check({nm, "_idle_after_halt"}, {30'b0, bus.read, bus.write}, 32'd0);
        check({nm, "_protocol"}, 32'(mon_viol - viol0), 32'd0);
    endtask

    // Instruction-level model: pc/npc pair gives the delay slot for free.
    task automatic ref_run(output logic [31:0] v0);
        logic [31:0] r [32];
        logic [31:0] pc, npc, ir, a, b, si, zi, tgt, ea, p4;
        logic [4:0]  rs_i, rt_i, rd_i;
        bit          br;
        int          steps;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        pc = 32'h4; npc = 32'h8; steps = 0;
        while (pc != 32'd0 && steps < 20000) begin
            ir = rmem[pc[10:2]];
            rs_i = ir[25:21]; rt_i = ir[20:16]; rd_i = ir[15:11];
            a = r[rs_i]; b = r[rt_i];
            si = {{16{ir[15]}}, ir[15:0]};
            zi = {16'h0, ir[15:0]};
            p4 = pc + 32'd4;
            ea = a + si;
            br = 1'b0;
            tgt = p4 + (si << 2);
            case (ir[31:26])
                6'h00: case (ir[5:0])
                    6'h21: r[rd_i] = a + b;
                    6'h23: r[rd_i] = a - b;
                    6'h24: r[rd_i] = a & b;
                    6'h25: r[rd_i] = a | b;
                    6'h26: r[rd_i] = a ^ b;
                    6'h2A: r[rd_i] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: r[rd_i] = (a < b) ? 32'd1 : 32'd0;
                    6'h00: r[rd_i] = b << ir[10:6];
                    6'h02: r[rd_i] = b >> ir[10:6];
                    6'h03: r[rd_i] = $signed(b) >>> ir[10:6];
                    6'h08: begin br = 1'b1; tgt = a; end
                    6'h09: begin br = 1'b1; tgt = a; r[rd_i] = pc + 32'd8; end
                    default: ;
                endcase
                6'h01: br = (rt_i == 5'd0) ? a[31] : ((rt_i == 5'd1) ? !a[31] : 1'b0);
                6'h02: begin br = 1'b1; tgt = {p4[31:28], ir[25:0], 2'b00}; end
                6'h03: begin br = 1'b1; tgt = {p4[31:28], ir[25:0], 2'b00}; r[31] = pc + 32'd8; end
                6'h04: br = (a == b);
                6'h05: br = (a != b);
                6'h06: br = ($signed(a) <= 0);
                6'h07: br = ($signed(a) > 0);
                6'h09: r[rt_i] = a + si;
                6'h0A: r[rt_i] = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
                6'h0B: r[rt_i] = (a < si) ? 32'd1 : 32'd0;
                6'h0C: r[rt_i] = a & zi;
                6'h0D: r[rt_i] = a | zi;
                6'h0E: r[rt_i] = a ^ zi;
                6'h0F: r[rt_i] = {ir[15:0], 16'h0};
                6'h23: r[rt_i] = rmem[ea[10:2]];
                6'h2B: rmem[ea[10:2]] = b;
                default: ;
            endcase
            r[0] = 32'd0;
            pc = npc;
            npc = br ? tgt : npc + 32'd4;
            steps++;
        end
        v0 = r[2];
    endtask

    task automatic build_random();
        int n, p, k, sub, off;
        bit prevbr;
        logic [31:0] w;
        for (int i = 0; i < 512; i++) load_buf[i] = 32'd0;
        for (int i = 0; i < 16; i++) load_buf[384 + i] = $urandom;
        n = 36; prevbr = 1'b0;
        for (p = 1; p <= n; p++) begin
            int d, s, t, im;
            d = $urandom_range(0, 7); s = $urandom_range(0, 7); t = $urandom_range(0, 7);
            im = $urandom_range(0, 65535);
            off = 'h600 + 4 * $urandom_range(0, 15);
            k = (!prevbr && p + 3 <= n) ? $urandom_range(0, 23) : $urandom_range(0, 18);
            prevbr = (k >= 19);
            case (k)
                0:  w = enc_i('h09, s, d, im);
                1:  w = enc_i('h0D, s, d, im);
                2:  w = enc_i('h0C, s, d, im);
                3:  w = enc_i('h0E, s, d, im);
                4:  w = enc_i('h0F, 0, d, im);
                5:  w = enc_i('h0A, s, d, im);
                6:  w = enc_i('h0B, s, d, im);
                7:  w = enc_r(s, t, d, 0, 'h21);
                8:  w = enc_r(s, t, d, 0, 'h23);
                9:  w = enc_r(s, t, d, 0, 'h24);
                10: w = enc_r(s, t, d, 0, 'h25);
                11: w = enc_r(s, t, d, 0, 'h26);
                12: w = enc_r(s, t, d, 0, 'h2A);
                13: w = enc_r(s, t, d, 0, 'h2B);
                14: w = enc_r(0, t, d, im % 32, 'h00);
                15: w = enc_r(0, t, d, im % 32, 'h02);
                16: w = enc_r(0, t, d, im % 32, 'h03);
                17: w = enc_i('h2B, 0, t, off);
                18: w = enc_i('h23, 0, d, off);
                19: w = enc_i('h04, s, t, 1 + $urandom_range(0, 1));
                20: w = enc_i('h05, s, t, 1 + $urandom_range(0, 1));
                21: begin
                    sub = $urandom_range(0, 3);
                    case (sub)
                        0: w = enc_i('h01, s, 0, 1 + $urandom_range(0, 1));
                        1: w = enc_i('h01, s, 1, 1 + $urandom_range(0, 1));
                        2: w = enc_i('h06, s, 0, 1 + $urandom_range(0, 1));
                        default: w = enc_i('h07, s, 0, 1 + $urandom_range(0, 1));
                    endcase
                end
                22: w = {6'h02, 26'(p + 2 + $urandom_range(0, 1))};
                default: w = {6'h03, 26'(p + 2 + $urandom_range(0, 1))};
            endcase
            load_buf[p] = w;
        end
        for (int r = 1; r < 32; r++) begin
            if (r != 2) begin
                load_buf[p] = enc_r(2, r, 2, 0, 'h26);
                p++;
            end
        end
        load_buf[p] = 32'h0000_0008;
        load_buf[p + 1] = 32'd0;
    endtask

    typedef struct {
        logic [31:0] prog [12];
        logic [31:0] exp;
        int          mode;
    } vec_t;
    vec_t vecs [8];

    initial begin
        int          viol0, cyc, c;
        bit          ok;
        logic [31:0] exp_v0;

        vecs[0].prog = '{32'h24020010, 32'h2403FFFB, 32'h1C600002, 32'h24420020, 32'h24420030, 32'h24420040,
                         32'h00000008, 0, 0, 0, 0, 0};
        vecs[0].exp = 32'h0000_00A0;
        vecs[1].prog = '{32'h24020010, 32'h24030005, 32'h1C600002, 32'h24420020, 32'h24420030, 32'h24420040,
                         32'h00000008, 0, 0, 0, 0, 0};
        vecs[1].exp = 32'h0000_0070;
        vecs[2].prog = '{32'h24020007, 32'h24000005, 32'h00001021, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].exp = 32'h0;
        vecs[3].prog = '{32'h3C021234, 32'h34425678, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].exp = 32'h1234_5678;
        vecs[4].prog = '{32'h0C000006, 32'h24020001, 32'h24420100, 32'h00000008, 32'h00000000, 32'h24420010,
                         32'h03E00008, 32'h24420002, 0, 0, 0, 0};
        vecs[4].exp = 32'h0000_0113;
        vecs[5].prog = '{32'h2403FFFF, 32'h24040001, 32'h0064102A, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].exp = 32'h1;
        vecs[6].prog = '{32'h2403FFFF, 32'h24040001, 32'h0064102B, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6].exp = 32'h0;
        vecs[7].prog = '{32'h2403FFFF, 32'h04600002, 32'h24020001, 32'h24420010, 32'h24420100, 32'h00000008,
                         0, 0, 0, 0, 0, 0};
        vecs[7].exp = 32'h0000_0101;

        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_active", 32'(active), 32'd1);
        check("rst_read_write", {30'b0, bus.read, bus.write}, 32'd0);
        check("rst_address", bus.address, 32'd0);
        check("rst_writedata", bus.writedata, 32'd0);
        check("rst_v0", register_v0, 32'd0);
        check("rst_byteenable", 32'(bus.byteenable), 32'hF);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 512; j++) load_buf[j] = 32'd0;
            for (int j = 0; j < 12; j++) load_buf[1 + j] = vecs[i].prog[j];
            stall_mode = i % 3;
            stall_n = 2;
            viol0 = mon_viol;
            commit_load();
            finish_run($sformatf("vec%0d", i), vecs[i].exp, viol0);
        end

        // Store/load round trip with every access stalled for three cycles.
        for (int j = 0; j < 512; j++) load_buf[j] = 32'd0;
        load_buf[1] = 32'h3C02DEAD; load_buf[2] = 32'h3442BEEF; load_buf[3] = 32'hAC020100;
        load_buf[4] = 32'h00001021; load_buf[5] = 32'h8C020100; load_buf[6] = 32'h00000008;
        stall_mode = 1; stall_n = 3;
        viol0 = mon_viol;
        commit_load();
        c = 0;
        while (!bus.write && c < 200) begin @(negedge clk); c++; end
        check("sw_strobe_seen", 32'(bus.write), 32'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("sw_stall%0d_strobes", j), {30'b0, bus.read, bus.write}, 32'd1);
            check($sformatf("sw_stall%0d_addr", j), bus.address, 32'h100);
            check($sformatf("sw_stall%0d_data", j), bus.writedata, 32'hDEADBEEF);
        end
        c = 0;
        while (!(bus.read && bus.address == 32'h100) && c < 200) begin @(negedge clk); c++; end
        check("lw_strobe_seen", 32'(bus.read && bus.address == 32'h100), 32'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("lw_stall%0d_strobes", j), {30'b0, bus.read, bus.write}, 32'd2);
            check($sformatf("lw_stall%0d_addr", j), bus.address, 32'h100);
        end
        finish_run("swlw", 32'hDEADBEEF, viol0);
        check("swlw_mem", mem[64], 32'hDEADBEEF);

        // Reset pulse in the middle of a run, then rerun to completion.
        for (int j = 0; j < 512; j++) load_buf[j] = 32'd0;
        for (int j = 0; j < 12; j++) load_buf[1 + j] = vecs[0].prog[j];
        stall_mode = 2;
        viol0 = mon_viol;
        commit_load();
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_active", 32'(active), 32'd1);
        check("midrst_strobes", {30'b0, bus.read, bus.write}, 32'd0);
        check("midrst_v0", register_v0, 32'd0);
        check("midrst_address", bus.address, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        c = 0;
        while (!bus.read && c < 50) begin @(negedge clk); c++; end
        check("midrst_refetch_addr", bus.read ? bus.address : 32'hFFFF_FFFF, 32'h4);
        wait_halt(4000, cyc, ok);
        check("midrst_halted", 32'(ok), 32'd1);
        check("midrst_under_1000", 32'(cyc < 1000), 32'd1);
        check("midrst_v0_final", register_v0, 32'h0000_00A0);
        repeat (6) @(negedge clk);
        check("midrst_protocol", 32'(mon_viol - viol0), 32'd0);

        for (int r = 0; r < 8; r++) begin
            build_random();
            rmem = load_buf;
            ref_run(exp_v0);
            stall_mode = 2;
            viol0 = mon_viol;
            commit_load();
            finish_run($sformatf("rnd%0d", r), exp_v0, viol0);
            for (int j = 0; j < 16; j++)
                check($sformatf("rnd%0d_mem%0d", r, j), mem[384 + j], rmem[384 + j]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
